// File: rtl/seq_det_pkg.sv
// Shared types and sizing helpers for the time-shared run-of-ones detector.
// Imported by the scheduler top and its round-robin arbiter.
package seq_det_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam int DEF_NCH     = 4;
   localparam int DEF_PAT_LEN = 3;
   localparam int DEF_CNT_W   = 8;

   // Index widths never collapse to zero bits, even for degenerate sizes.
   function automatic int ch_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int ctx_w(input int pat_len);
      return (pat_len < 2) ? 1 : $clog2(pat_len);
   endfunction

   localparam int DEF_CH_W  = ch_w(DEF_NCH);
   localparam int DEF_CTX_W = ctx_w(DEF_PAT_LEN);

endpackage

// File: rtl/seq_det_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping
// modulo N. The pointer register itself lives in the caller.
module rr_arbiter
   import seq_det_pkg::*;
#(
   parameter int N = DEF_NCH,
   parameter int W = ch_w(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   input  logic         en,
   output logic [N-1:0] gnt,
   output logic [W-1:0] gnt_idx,
   output logic         gnt_any
);

   always_comb begin
      int idx;
      idx     = 0;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      if (en) begin
         for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!gnt_any && req[idx]) begin
               gnt[idx] = 1'b1;
               gnt_idx  = W'(idx);
               gnt_any  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/seq_det_sched.sv
// Shared Mealy "PAT_LEN consecutive ones" detector time-multiplexed over NCH
// serial channels, with per-channel run-length context and hit counters.
module seq_det_sched
   import seq_det_pkg::*;
#(
   parameter int NCH     = DEF_NCH,
   parameter int PAT_LEN = DEF_PAT_LEN,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [NCH-1:0]           bit_valid,
   input  logic [NCH-1:0]           bit_data,
   output logic [NCH-1:0]           bit_ready,
   input  logic [NCH-1:0]           clr_ch,
   output logic                     det_valid,
   output logic [$clog2(NCH)-1:0]   det_ch,
   output logic [NCH*CNT_W-1:0]     hit_cnt
);

   localparam int CH_W  = ch_w(NCH);
   localparam int CTX_W = ctx_w(PAT_LEN);
   localparam logic [CTX_W-1:0] CTX_MAX = CTX_W'(PAT_LEN - 1);
   localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NCH - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_t              state, state_nxt;
   logic [CH_W-1:0]     rr_ptr;
   logic [CTX_W-1:0]    ctx [NCH];
   logic [CNT_W-1:0]    cnt [NCH];

   logic [NCH-1:0]      req_p0;
   logic [NCH-1:0]      gnt_p0;
   logic [CH_W-1:0]     gnt_idx_p0;
   logic                gnt_any_p0;
   logic                bit_p0;
   logic                hit_p0;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = en ? RUN : PAUSE;
         RUN:     if (!en) state_nxt = PAUSE;
         PAUSE:   if (en)  state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // stage p0: arbitration, context lookup and hit decision
   assign req_p0 = bit_valid & ~clr_ch;

   rr_arbiter #(
      .N (NCH),
      .W (CH_W)
   ) u_arb (
      .req     (req_p0),
      .ptr     (rr_ptr),
      .en      (state == RUN),
      .gnt     (gnt_p0),
      .gnt_idx (gnt_idx_p0),
      .gnt_any (gnt_any_p0)
   );

   assign bit_ready = gnt_p0;
   assign bit_p0    = bit_data[gnt_idx_p0];
   assign hit_p0    = gnt_any_p0 && bit_p0 && (ctx[gnt_idx_p0] == CTX_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (gnt_any_p0) begin
         rr_ptr <= (gnt_idx_p0 == LAST_CH) ? '0 : gnt_idx_p0 + 1'b1;
      end
   end

   // A cleared channel is never granted, so clear and update cannot collide.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (rst || clr_ch[i]) begin
            ctx[i] <= '0;
         end else if (gnt_p0[i]) begin
            if (!bit_p0 || ctx[i] == CTX_MAX) ctx[i] <= '0;
            else                              ctx[i] <= ctx[i] + 1'b1;
         end
      end
   end

   // stage p1: registered hit pulse, channel tag and counters
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (rst)                     cnt[i] <= '0;
         else if (hit_p0 && gnt_p0[i]) cnt[i] <= sat_inc(cnt[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         det_valid <= 1'b0;
         det_ch    <= '0;
      end else begin
         det_valid <= hit_p0;
         if (hit_p0) det_ch <= gnt_idx_p0;
      end
   end

   for (genvar gi = 0; gi < NCH; gi++) begin : g_cnt_out
      assign hit_cnt[gi*CNT_W +: CNT_W] = cnt[gi];
   end

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed bench for seq_det_sched: a cycle model predicts grants and pushes
// expected detector outputs to a scoreboard queue, checked one cycle later.
module tb_seq_det_sched;

   localparam int NCH     = 4;
   localparam int PAT_LEN = 3;
   localparam int CNT_W   = 2;
   localparam int CH_W    = 2;

   logic                   clk;
   logic                   rst;
   logic                   en;
   logic [NCH-1:0]         bit_valid;
   logic [NCH-1:0]         bit_data;
   logic [NCH-1:0]         bit_ready;
   logic [NCH-1:0]         clr_ch;
   logic                   det_valid;
   logic [CH_W-1:0]        det_ch;
   logic [NCH*CNT_W-1:0]   hit_cnt;

   seq_det_sched #(
      .NCH     (NCH),
      .PAT_LEN (PAT_LEN),
      .CNT_W   (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .bit_valid (bit_valid),
      .bit_data  (bit_data),
      .bit_ready (bit_ready),
      .clr_ch    (clr_ch),
      .det_valid (det_valid),
      .det_ch    (det_ch),
      .hit_cnt   (hit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic                 v;
      logic [CH_W-1:0]      ch;
      logic [NCH*CNT_W-1:0] cnt;
   } exp_t;

   exp_t q[$];

   int vec  = 0;
   int misc = 0;
   int ndet = 0;

   // reference model: 0 = IDLE, 1 = RUN, 2 = PAUSE
   int m_state;
   int m_ptr;
   int m_ctx [NCH];
   int m_cnt [NCH];
   int m_detch;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp)
      else begin
         misc++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_ptr   = 0;
      m_detch = 0;
      for (int i = 0; i < NCH; i++) begin
         m_ctx[i] = 0;
         m_cnt[i] = 0;
      end
      q.delete();
      ndet = 0;
   endtask

   // Hold rst over two edges, check reset outputs, release at a falling edge.
   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();
      chk("rst_det_valid", det_valid, 0);
      chk("rst_det_ch", det_ch, 0);
      chk("rst_hit_cnt", hit_cnt, 0);
      chk("rst_bit_ready", bit_ready, 0);
      rst = 1'b0;
   endtask

   // One clock: predict and check the grant, advance the model, push the
   // expected outputs, then pop and compare them after the edge.
   task automatic tick();
      int   g;
      int   idx;
      exp_t e;
      exp_t o;
      logic [NCH-1:0]       exp_rdy;
      logic [NCH*CNT_W-1:0] flat;
      #1;
      g = -1;
      if (m_state == 1) begin
         for (int k = 0; k < NCH; k++) begin
            idx = (m_ptr + k) % NCH;
            if (g < 0 && bit_valid[idx] && !clr_ch[idx]) g = idx;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("bit_ready", bit_ready, exp_rdy);

      e.v = 1'b0;
      if (g >= 0) begin
         if (bit_data[g]) begin
            if (m_ctx[g] == PAT_LEN - 1) begin
               m_ctx[g] = 0;
               if (m_cnt[g] < (1 << CNT_W) - 1) m_cnt[g]++;
               e.v = 1'b1;
               m_detch = g;
            end else begin
               m_ctx[g]++;
            end
         end else begin
            m_ctx[g] = 0;
         end
         m_ptr = (g + 1) % NCH;
      end
      for (int i = 0; i < NCH; i++)
         if (clr_ch[i]) m_ctx[i] = 0;
      case (m_state)
         0:       m_state = en ? 1 : 2;
         1:       m_state = en ? 1 : 2;
         default: m_state = en ? 1 : 2;
      endcase
      flat = '0;
      for (int i = 0; i < NCH; i++) flat[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
      e.ch  = CH_W'(m_detch);
      e.cnt = flat;
      q.push_back(e);

      @(posedge clk);
      @(negedge clk);
      if (det_valid === 1'b1) ndet++;
      if (q.size() == 0) begin
         chk("sb_empty", 0, 1);
      end else begin
         o = q.pop_front();
         chk("det_valid", det_valid, o.v);
         chk("det_ch", det_ch, o.ch);
         chk("hit_cnt", hit_cnt, o.cnt);
      end
   endtask

   int pat [6] = '{1, 1, 0, 1, 1, 1};

   initial begin
      rst       = 1'b1;
      en        = 1'b0;
      bit_valid = '0;
      bit_data  = '0;
      clr_ch    = '0;

      // single channel stream of six ones
      do_reset();
      en        = 1'b1;
      bit_valid = 4'b0001;
      bit_data  = 4'b0001;
      repeat (7) tick();
      chk("ch0_ndet", ndet, 2);
      chk("ch0_cnt", hit_cnt[1:0], 2);

      // all channels continuously valid with constant ones
      do_reset();
      en        = 1'b1;
      bit_valid = 4'b1111;
      bit_data  = 4'b1111;
      repeat (13) tick();
      chk("all_ndet", ndet, 4);
      chk("all_cnt", hit_cnt, 8'h55);

      // zero in the middle restarts the run
      do_reset();
      en        = 1'b1;
      bit_valid = 4'b0100;
      bit_data  = 4'b0000;
      tick();
      for (int i = 0; i < 6; i++) begin
         bit_data[2] = pat[i][0];
         tick();
      end
      chk("ch2_ndet", ndet, 1);
      chk("ch2_cnt", hit_cnt[5:4], 1);

      // clear pulse discards the partial run without losing a bit
      do_reset();
      en        = 1'b1;
      bit_valid = 4'b0010;
      bit_data  = 4'b0010;
      repeat (3) tick();
      clr_ch = 4'b0010;
      tick();
      clr_ch = 4'b0000;
      tick();
      chk("clr_no_hit", ndet, 0);
      repeat (2) tick();
      chk("clr_ndet", ndet, 1);

      // counter saturation on channel 3
      do_reset();
      en        = 1'b1;
      bit_valid = 4'b1000;
      bit_data  = 4'b1000;
      repeat (16) tick();
      chk("sat_ndet", ndet, 5);
      chk("sat_cnt", hit_cnt[7:6], 3);

      // pause with context retained across the gap
      do_reset();
      en        = 1'b1;
      bit_valid = 4'b0001;
      bit_data  = 4'b0001;
      repeat (3) tick();
      en        = 1'b0;
      bit_valid = 4'b0000;
      tick();
      bit_valid = 4'b0001;
      repeat (9) tick();
      en = 1'b1;
      tick();
      chk("pause_no_hit", ndet, 0);
      tick();
      chk("resume_hit", ndet, 1);

      // reset mid-run discards the partial count
      do_reset();
      en        = 1'b1;
      bit_valid = 4'b0001;
      bit_data  = 4'b0001;
      repeat (3) tick();
      do_reset();
      repeat (3) tick();
      chk("midrst_ndet", ndet, 0);

      bit_valid = '0;
      $display("== %0d vectors applied, %0d miscompares ==", vec, misc);
      $finish;
   end

endmodule

// File: doc/seq_det_sched.md
# seq_det_sched

Time-shared, non-overlapping "run of PAT_LEN ones" detector serving NCH independent serial bit channels.
- A round-robin scheduler grants at most one channel per cycle to a single shared Mealy detection datapath.
- Per-channel run-length context is saved and restored between grants.
- Sits between the serial front-end channel FIFOs and the event/interrupt logic; replaces one detector instance per channel.

## Interface
Parameters:
- NCH, 4, number of serial channels (2..8)
- PAT_LEN, 3, number of consecutive 1s that constitutes a hit (2..15)
- CNT_W, 8, width of each per-channel hit counter

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- en  in  1  scheduler enable; low = no grants
- bit_valid  in  NCH  per-channel bit available
- bit_data  in  NCH  per-channel bit value
- bit_ready  out  NCH  one-hot grant; bit accepted when valid & ready
- clr_ch  in  NCH  per-channel context clear (level, sampled each cycle)
- det_valid  out  1  registered hit pulse
- det_ch  out  $clog2(NCH)  channel index of the hit
- hit_cnt  out  NCH*CNT_W  per-channel saturating hit counters; channel i at [i*CNT_W +: CNT_W]

## Operation
- Control FSM states: IDLE, RUN, PAUSE.
  - IDLE: entered on rst; lasts exactly 1 cycle; then RUN if en=1, else PAUSE.
  - RUN → PAUSE when en=0.
  - PAUSE → RUN when en=1.
  - bit_ready is all-zero in IDLE and PAUSE.
- Arbitration, RUN only:
  - Candidates are channels with bit_valid=1 and clr_ch=0.
  - Search begins at rr_ptr and wraps modulo NCH; the first candidate is granted.
  - bit_ready is combinational from bit_valid, clr_ch, rr_ptr and state.
  - On a grant to channel g, rr_ptr <= (g+1) mod NCH. With no grant, rr_ptr holds.
- Context:
  - ctx[i] is a $clog2(PAT_LEN)-bit run count, range 0..PAT_LEN-1.
  - On an accepted bit for channel g:
    - bit=0: ctx[g] <= 0.
    - bit=1 and ctx[g]==PAT_LEN-1: hit; ctx[g] <= 0 (non-overlapping).
    - bit=1 otherwise: ctx[g] <= ctx[g]+1.
- Clear: clr_ch[i]=1 forces ctx[i] <= 0 that cycle. The channel is ineligible for grant, so no bit is lost; hit_cnt[i] is unaffected.
- Hit reporting:
  - det_valid <= hit; det_ch <= g.
  - det_ch holds its last value when det_valid=0.
  - hit_cnt[g] increments on a hit and saturates at 2^CNT_W-1.
- Reset values:
  - state=IDLE, rr_ptr=0, all ctx=0, all hit_cnt=0.
  - det_valid=0, det_ch=0, bit_ready=0.
- Reset mid-operation: all context is discarded; a run in progress never produces a hit afterwards.

## Timing
- Accept-to-det_valid latency: exactly 1 cycle, i.e. det_valid is high the cycle after the accepting edge.
- hit_cnt updates on the same edge that asserts det_valid.
- Throughput: 1 bit per cycle aggregate. With all NCH channels continuously valid, each channel is granted once every NCH cycles.
- en deasserted: the grant stops the cycle after the en=0 sample (FSM registered). A bit accepted in the final RUN cycle is still processed.
- Back-to-back hits on different channels produce consecutive det_valid cycles with distinct det_ch.
- First cycle after rst deassertion is IDLE: no grant, even with valid asserted.

## Structure
- Package seq_det_pkg:
  - state enum (IDLE/RUN/PAUSE)
  - default NCH/PAT_LEN/CNT_W constants
  - CH_W = $clog2(NCH) and CTX_W = $clog2(PAT_LEN) localparam helpers
- Sub-module rr_arbiter:
  - parameter N
  - inputs req[N], ptr, en; outputs gnt[N] one-hot, gnt_idx, gnt_any
  - purely combinational; rr_ptr register stays in seq_det_sched
- Top holds the FSM, ctx array, hit counters and output registers.

## Test plan
- Reset release, channel 0 streams 1,1,1,1,1,1 with bit_valid held → no grant in IDLE cycle; det_valid twice, after 3rd and 6th accepted bit; det_ch=0; hit_cnt[0]=2.
- All 4 channels valid, each sending constant 1 → grants cycle 0,1,2,3,0,...; hits on ch0..ch3 on consecutive cycles after each channel's 3rd grant.
- Channel 2 sends 1,1,0,1,1,1 → exactly one hit (after the 6th bit); ctx reset by the 0 verified.
- Channel 1 sends 1,1, then clr_ch[1] pulsed for 1 cycle (bit_valid held), then 1 → no grant during the clear; no hit after the next 1; two more 1s give a hit.
- CNT_W=2, channel 3 produces 5 hits → hit_cnt[3] stops at 3; det_valid still pulses 5 times.
- en dropped mid-stream with ctx[0]=2, held low 10 cycles, then raised, then one 1 on ch0 → no grants while paused; hit immediately on resume (context retained).
